// File: rtl/rv32i_mc.sv
// Multi-cycle RV32I core: FETCH/EXEC/MEM/TRAP, 2 cycles per ALU op and 3 per load/store with zero-wait memory.
// Requests hold address/data stable until ack; an ack while the matching request is low is ignored.
module rv32i_mc #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0010,
  parameter bit          HALT_ON_TRAP = 1'b1,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             inst_req,
  input  logic             inst_ack,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst_rdata,
  output logic             data_req,
  input  logic             data_ack,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  output logic [3:0]       data_we,
  input  logic [31:0]      data_rdata,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_ir;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_instret;
  logic [31:0]      r_rf [0:31];

  logic [31:0] r_maddr;
  logic [1:0]  r_mofs;
  logic [31:0] r_mwdata;
  logic [3:0]  r_mwe;
  logic [2:0]  r_mf3;
  logic [4:0]  r_mrd;
  logic        r_mload;

  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_pc4;

  assign w_op   = r_ir[6:0];
  assign w_rd   = r_ir[11:7];
  assign w_f3   = r_ir[14:12];
  assign w_rs1  = r_ir[19:15];
  assign w_rs2  = r_ir[24:20];
  assign w_f7b5 = r_ir[30];

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'b0};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  assign w_pc4   = r_pc + 32'd4;

  logic [31:0] w_alu_b, w_alu;
  logic [4:0]  w_shamt;

  assign w_alu_b = (w_op == OP_REG) ? w_rs2_val : w_imm_i;
  assign w_shamt = w_alu_b[4:0];

  always_comb begin
    w_alu = 32'd0;
    case (w_f3)
      3'b000:  w_alu = (w_op == OP_REG && w_f7b5) ? w_rs1_val - w_alu_b : w_rs1_val + w_alu_b;
      3'b001:  w_alu = w_rs1_val << w_shamt;
      3'b010:  w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
      3'b011:  w_alu = {31'd0, w_rs1_val < w_alu_b};
      3'b100:  w_alu = w_rs1_val ^ w_alu_b;
      3'b101:  w_alu = w_f7b5 ? $signed(w_rs1_val) >>> w_shamt : w_rs1_val >> w_shamt;
      3'b110:  w_alu = w_rs1_val | w_alu_b;
      default: w_alu = w_rs1_val & w_alu_b;
    endcase
  end

  logic w_taken;

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (w_rs1_val == w_rs2_val);
      3'b001:  w_taken = (w_rs1_val != w_rs2_val);
      3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
      3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
      3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
      3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  logic [31:0] w_jal_tgt, w_jalr_tgt, w_br_tgt, w_ls_addr;
  logic        w_ls_misal;

  assign w_jal_tgt  = r_pc + w_imm_j;
  assign w_jalr_tgt = (w_rs1_val + w_imm_i) & ~32'd1;
  assign w_br_tgt   = r_pc + w_imm_b;
  assign w_ls_addr  = w_rs1_val + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_ls_misal = ((w_f3[1:0] == 2'b10) && (w_ls_addr[1:0] != 2'b00)) ||
                      ((w_f3[1:0] == 2'b01) && w_ls_addr[0]);

  // Store data is replicated across lanes; only the write enables select bytes.
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_we;

  always_comb begin
    w_st_wdata = w_rs2_val;
    w_st_we    = 4'b1111;
    case (w_f3[1:0])
      2'b00: begin
        w_st_wdata = {4{w_rs2_val[7:0]}};
        w_st_we    = 4'b0001 << w_ls_addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{w_rs2_val[15:0]}};
        w_st_we    = w_ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = w_rs2_val;
        w_st_we    = 4'b1111;
      end
    endcase
  end

  logic [31:0] w_next_pc, w_wb_val;
  logic        w_wb_en, w_mem, w_exc;
  logic [1:0]  w_cause;

  always_comb begin
    w_next_pc = w_pc4;
    w_wb_en   = 1'b0;
    w_wb_val  = w_alu;
    w_mem     = 1'b0;
    w_exc     = 1'b0;
    w_cause   = 2'd0;
    case (w_op)
      OP_LUI:   begin w_wb_en = 1'b1; w_wb_val = w_imm_u; end
      OP_AUIPC: begin w_wb_en = 1'b1; w_wb_val = r_pc + w_imm_u; end
      OP_IMM, OP_REG: w_wb_en = 1'b1;
      OP_FENCE: w_wb_en = 1'b0;
      OP_JAL: begin
        if (w_jal_tgt[1]) begin
          w_exc = 1'b1; w_cause = 2'd1;
        end else begin
          w_wb_en = 1'b1; w_wb_val = w_pc4; w_next_pc = w_jal_tgt;
        end
      end
      OP_JALR: begin
        if (w_jalr_tgt[1]) begin
          w_exc = 1'b1; w_cause = 2'd1;
        end else begin
          w_wb_en = 1'b1; w_wb_val = w_pc4; w_next_pc = w_jalr_tgt;
        end
      end
      OP_BRANCH: begin
        if (w_taken && w_br_tgt[1]) begin
          w_exc = 1'b1; w_cause = 2'd1;
        end else if (w_taken) begin
          w_next_pc = w_br_tgt;
        end
      end
      OP_LOAD, OP_STORE: begin
        if (w_ls_misal) begin
          w_exc = 1'b1; w_cause = 2'd2;
        end else begin
          w_mem = 1'b1;
        end
      end
      OP_SYSTEM: begin w_exc = 1'b1; w_cause = 2'd3; end
      default:   begin w_exc = 1'b1; w_cause = 2'd0; end
    endcase
  end

  logic [31:0] w_lane, w_ld_val;

  assign w_lane = data_rdata >> {r_mofs, 3'b000};

  always_comb begin
    w_ld_val = w_lane;
    case (r_mf3)
      3'b000:  w_ld_val = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld_val = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ld_val = {24'd0, w_lane[7:0]};
      3'b101:  w_ld_val = {16'd0, w_lane[15:0]};
      default: w_ld_val = w_lane;
    endcase
  end

  logic        w_rf_we;
  logic [4:0]  w_rf_wa;
  logic [31:0] w_rf_wd;

  always_comb begin
    w_rf_we = 1'b0;
    w_rf_wa = w_rd;
    w_rf_wd = w_wb_val;
    if (r_state == S_EXEC && !w_exc && !w_mem && w_wb_en) begin
      w_rf_we = 1'b1;
    end else if (r_state == S_MEM && data_ack && r_mload) begin
      w_rf_we = 1'b1;
      w_rf_wa = r_mrd;
      w_rf_wd = w_ld_val;
    end
  end

  // Register file is deliberately left out of reset; only gated so reset cycles never write it.
  always_ff @(posedge clk) begin
    if (reset && w_rf_we && (w_rf_wa != 5'd0))
      r_rf[w_rf_wa] <= w_rf_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= NOP;
      r_cause   <= 2'd0;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (inst_ack) begin
            r_ir    <= inst_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_exc) begin
            r_cause <= w_cause;
            r_state <= S_TRAP;
          end else if (w_mem) begin
            r_maddr  <= {w_ls_addr[31:2], 2'b00};
            r_mofs   <= w_ls_addr[1:0];
            r_mwdata <= (w_op == OP_STORE) ? w_st_wdata : 32'd0;
            r_mwe    <= (w_op == OP_STORE) ? w_st_we : 4'b0000;
            r_mf3    <= w_f3;
            r_mrd    <= w_rd;
            r_mload  <= (w_op == OP_LOAD);
            r_state  <= S_MEM;
          end else begin
            r_pc      <= w_next_pc;
            r_instret <= r_instret + CNT_W'(1);
            r_state   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (data_ack) begin
            r_pc      <= w_pc4;
            r_instret <= r_instret + CNT_W'(1);
            r_state   <= S_FETCH;
          end
        end
        default: begin
          if (!HALT_ON_TRAP) begin
            r_pc    <= TRAP_VEC;
            r_state <= S_FETCH;
          end
        end
      endcase
    end
  end

  assign inst_req   = (r_state == S_FETCH);
  assign inst_addr  = r_pc;
  assign data_req   = (r_state == S_MEM);
  assign data_addr  = r_maddr;
  assign data_wdata = r_mwdata;
  assign data_we    = (r_state == S_MEM) ? r_mwe : 4'b0000;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_rv32i_mc.sv
// Directed-program bench for rv32i_mc: halting core plus a redirect-on-trap instance sharing one instruction ROM.
module tb_rv32i_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset2;
  logic        inst_req, inst_ack, data_req, data_ack, trap;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata, instret;
  logic [3:0]  data_we;
  logic [1:0]  trap_cause;

  logic        inst_req2, inst_ack2, data_req2, data_ack2, trap2;
  logic [31:0] inst_addr2, inst_rdata2, data_addr2, data_wdata2, data_rdata2, instret2;
  logic [3:0]  data_we2;
  logic [1:0]  trap_cause2;

  rv32i_mc dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_ack(inst_ack), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_ack(data_ack), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_we(data_we), .data_rdata(data_rdata),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  rv32i_mc #(.HALT_ON_TRAP(1'b0)) dut2 (
    .clk(clk), .reset(reset2),
    .inst_req(inst_req2), .inst_ack(inst_ack2), .inst_addr(inst_addr2), .inst_rdata(inst_rdata2),
    .data_req(data_req2), .data_ack(data_ack2), .data_addr(data_addr2), .data_wdata(data_wdata2),
    .data_we(data_we2), .data_rdata(data_rdata2),
    .trap(trap2), .trap_cause(trap_cause2), .instret(instret2)
  );

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  logic        dack_en, dack_force;
  int          dack_wait;
  int          dcnt = 0;

  always_comb begin
    inst_ack    = inst_req;
    inst_rdata  = imem[inst_addr[7:2]];
    data_ack    = dack_force | (data_req & dack_en & (dcnt >= dack_wait));
    data_rdata  = dmem[data_addr[5:2]];
    inst_ack2   = inst_req2;
    inst_rdata2 = imem[inst_addr2[7:2]];
    data_ack2   = data_req2;
    data_rdata2 = 32'd0;
  end

  always @(posedge clk) begin
    if (data_req && !data_ack) dcnt <= dcnt + 1;
    else                       dcnt <= 0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'd0;
      dmem[2] <= 32'h1234_5678;
    end else if (data_req && data_ack) begin
      for (int b = 0; b < 4; b++)
        if (data_we[b]) dmem[data_addr[5:2]][8*b +: 8] <= data_wdata[8*b +: 8];
    end
  end

  int          dreq_cycles = 0;
  int          wefull_cycles = 0;
  logic [3:0]  last_we;
  logic [31:0] last_wdata, last_daddr;

  always @(negedge clk) begin
    if (data_req) begin
      dreq_cycles <= dreq_cycles + 1;
      if (data_we == 4'hF) wefull_cycles <= wefull_cycles + 1;
      last_we    <= data_we;
      last_wdata <= data_wdata;
      last_daddr <= data_addr;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_pc(input string tag, input logic [31:0] target, input int budget,
                              output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if (inst_req && inst_addr == target) break;
    end
    check(tag, inst_req ? inst_addr : 32'hDEAD_DEAD, target);
  endtask

  int cyc;
  int snap;

  initial begin
    reset      = 1'b0;
    reset2     = 1'b0;
    dack_en    = 1'b1;
    dack_force = 1'b0;
    dack_wait  = 2;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    imem[0]  = 32'h0050_0093; // ADDI x1,x0,5
    imem[1]  = 32'hFF90_8113; // ADDI x2,x1,-7
    imem[2]  = 32'h0020_2023; // SW   x2,0(x0)
    imem[3]  = 32'h0030_0183; // LB   x3,3(x0)
    imem[4]  = 32'h0020_6463; // BLTU x0,x2,+8
    imem[6]  = 32'h0020_4463; // BLT  x0,x2,+8
    imem[7]  = 32'h0090_0213; // ADDI x4,x0,9
    imem[8]  = 32'h0010_0013; // ADDI x0,x0,1
    imem[9]  = 32'h0000_0233; // ADD  x4,x0,x0
    imem[10] = 32'h0080_02EF; // JAL  x5,+8
    imem[12] = 32'h00D2_8367; // JALR x6,13(x5)
    imem[14] = 32'h0020_02A3; // SB   x2,5(x0)
    imem[15] = 32'h0040_5383; // LHU  x7,4(x0)
    imem[16] = 32'h0000_0073; // ECALL

    repeat (2) @(posedge clk);
    #1;
    check("rst_inst_req", {31'd0, inst_req}, 32'd1);
    check("rst_data_req", {31'd0, data_req}, 32'd0);
    check("rst_data_we", {28'd0, data_we}, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_pc", inst_addr, 32'd0);

    @(negedge clk) reset = 1'b1;
    repeat (4) tick();
    check("addi_instret", instret, 32'd2);
    check("addi_pc", inst_addr, 32'd8);
    check("addi_x1", dut.r_rf[1], 32'd5);
    check("addi_x2", dut.r_rf[2], 32'hFFFF_FFFE);

    snap = wefull_cycles;
    run_until_pc("sw_done", 32'd12, 20, cyc);
    check("sw_we_cycles", wefull_cycles - snap, 32'd3);
    check("sw_cycles", cyc, 32'd5);
    check("sw_mem", dmem[0], 32'hFFFF_FFFE);
    run_until_pc("lb_done", 32'd16, 20, cyc);
    check("lb_x3", dut.r_rf[3], 32'hFFFF_FFFF);
    check("lb_instret", instret, 32'd4);

    run_until_pc("bltu_taken", 32'd24, 6, cyc);
    check("bltu_cycles", cyc, 32'd2);
    run_until_pc("blt_not_taken", 32'd28, 6, cyc);
    check("blt_cycles", cyc, 32'd2);

    dack_wait = 0;
    run_until_pc("addi_x4", 32'd32, 6, cyc);
    check("alu_cycles", cyc, 32'd2);
    run_until_pc("jalr_done", 32'd56, 40, cyc);
    check("x0_read_zero_x4", dut.r_rf[4], 32'd0);
    check("jal_link_x5", dut.r_rf[5], 32'd44);
    check("jalr_link_x6", dut.r_rf[6], 32'd52);
    run_until_pc("sb_done", 32'd60, 6, cyc);
    check("sb_cycles", cyc, 32'd3);
    check("sb_we", {28'd0, last_we}, 32'h0000_0002);
    check("sb_wdata", last_wdata, 32'hFEFE_FEFE);
    check("sb_addr", last_daddr, 32'd4);
    run_until_pc("lhu_done", 32'd64, 6, cyc);
    check("lhu_x7", dut.r_rf[7], 32'h0000_FE00);
    check("sb_mem", dmem[1], 32'h0000_FE00);

    repeat (2) tick();
    check("ecall_trap", {31'd0, trap}, 32'd1);
    check("ecall_cause", {30'd0, trap_cause}, 32'd3);
    check("ecall_instret", instret, 32'd13);
    repeat (3) tick();
    check("halt_trap_held", {31'd0, trap}, 32'd1);
    check("halt_no_fetch", {31'd0, inst_req}, 32'd0);

    @(negedge clk);
    reset  = 1'b0;
    reset2 = 1'b0;
    imem[0] = 32'h0020_2083; // LW x1,2(x0)
    imem[4] = 32'h0000_0013; // NOP at TRAP_VEC
    snap = dreq_cycles;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    reset2 = 1'b1;
    repeat (2) tick();
    check("lw_misal_trap", {31'd0, trap}, 32'd1);
    check("lw_misal_cause", {30'd0, trap_cause}, 32'd2);
    check("lw_misal_instret", instret, 32'd0);
    check("vec_trap", {31'd0, trap2}, 32'd1);
    check("vec_cause", {30'd0, trap_cause2}, 32'd2);
    tick();
    check("vec_trap_one_cycle", {31'd0, trap2}, 32'd0);
    check("vec_fetch_req", {31'd0, inst_req2}, 32'd1);
    check("vec_pc", inst_addr2, 32'h0000_0010);
    check("lw_misal_no_dreq", dreq_cycles - snap, 32'd0);
    check("rf_kept_over_reset", dut.r_rf[2], 32'hFFFF_FFFE);

    @(negedge clk);
    reset   = 1'b0;
    reset2  = 1'b0;
    dack_en = 1'b0;
    imem[0] = 32'h0080_2083; // LW x1,8(x0)
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2) tick();
    check("mem_req_up", {31'd0, data_req}, 32'd1);
    check("mem_addr", data_addr, 32'd8);
    tick();
    @(negedge clk) reset = 1'b0;
    tick();
    check("abort_dreq", {31'd0, data_req}, 32'd0);
    check("abort_ireq", {31'd0, inst_req}, 32'd1);
    check("abort_pc", inst_addr, 32'd0);
    @(negedge clk);
    reset      = 1'b1;
    dack_force = 1'b1;
    tick();
    check("late_ack_instret", instret, 32'd0);
    check("late_ack_no_dreq", {31'd0, data_req}, 32'd0);
    @(negedge clk);
    dack_force = 1'b0;
    dack_en    = 1'b1;
    run_until_pc("refetch_lw", 32'd4, 10, cyc);
    check("refetch_cycles", cyc, 32'd2);
    check("refetch_instret", instret, 32'd1);
    check("refetch_x1", dut.r_rf[1], 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
